// File: rtl/sha3_scan_pkg.sv
// Shared constants and types for the SHA3 scan result readout path.
package sha3_scan_pkg;

    localparam int HASH_LANES       = 25;
    localparam int HASH_WORDS32     = 50;
    localparam int RESULT_PKT_WORDS = 51;
    localparam int LANE_W           = 64;

    typedef logic [5:0] word_idx_t;

    localparam word_idx_t LAST_WORD = word_idx_t'(RESULT_PKT_WORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } disp_state_t;

    // Index width for n items, never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester strictly after last_grant.
module rr_arbiter
    import sha3_scan_pkg::*;
#(
    parameter int N = 4,
    localparam int W = idx_width(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] grant_idx,
    output logic         grant_valid
);

    // Scan offsets from farthest to nearest so the nearest requester wins the last assignment
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int off = N; off >= 1; off--) begin
            if (req[(int'(last_grant) + off) % N]) begin
                grant_idx   = W'((int'(last_grant) + off) % N);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha3_result_dispatcher.sv
// Captures scanner results into one-deep slots and serializes them round-robin
// as 51-word valid/ready packets; results hitting an occupied slot are counted as drops.
module sha3_result_dispatcher
    import sha3_scan_pkg::*;
#(
    parameter int NUM_SCANNERS = 4,
    parameter int DROP_CNT_W   = 16,
    localparam int SRC_W       = idx_width(NUM_SCANNERS),
    localparam int SLOT_W      = HASH_LANES * LANE_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_SCANNERS-1:0]          in_found,
    input  logic [NUM_SCANNERS*SLOT_W-1:0]   in_hash,
    input  logic [NUM_SCANNERS*32-1:0]       in_nonce,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [31:0]                      out_data,
    output logic                             out_last,
    output logic [SRC_W-1:0]                 out_source,
    output logic [NUM_SCANNERS-1:0]          pending,
    output logic [DROP_CNT_W-1:0]            drop_count
);

    localparam int SUM_W = DROP_CNT_W + 5;

    disp_state_t state, next_state;
    word_idx_t   word_idx;
    word_idx_t   word_m1;
    logic [4:0]  lane_sel;

    logic [SRC_W-1:0] last_grant;
    logic [SRC_W-1:0] grant_idx;
    logic             grant_valid;

    logic [NUM_SCANNERS-1:0] slot_free;
    logic [NUM_SCANNERS-1:0] capture;
    logic [NUM_SCANNERS-1:0] drop;
    logic                    accept;
    logic                    last_accept;

    logic [4:0]            drop_num;
    logic [SUM_W-1:0]      drop_sum;
    logic [DROP_CNT_W-1:0] drop_next;

    logic [HASH_LANES-1:0][LANE_W-1:0] hash_reg  [NUM_SCANNERS];
    logic [31:0]                       nonce_reg [NUM_SCANNERS];

    rr_arbiter #(
        .N(NUM_SCANNERS)
    ) u_arb (
        .req         (pending),
        .last_grant  (last_grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // A slot accepts a new result when empty or when its final word leaves this cycle
    always_comb begin
        accept      = out_valid & out_ready;
        last_accept = accept && (word_idx == LAST_WORD);
        for (int i = 0; i < NUM_SCANNERS; i++) begin
            slot_free[i] = !pending[i] || (last_accept && (out_source == SRC_W'(i)));
            capture[i]   = in_found[i] & slot_free[i];
            drop[i]      = in_found[i] & !slot_free[i];
        end
    end

    // Latch hash and nonce into each slot on capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_SCANNERS; i++) begin
                hash_reg[i]  <= '0;
                nonce_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SCANNERS; i++) begin
                if (capture[i]) begin
                    hash_reg[i]  <= in_hash[i*SLOT_W +: SLOT_W];
                    nonce_reg[i] <= in_nonce[i*32 +: 32];
                end
            end
        end
    end

    // Slot occupancy: set on capture, cleared when the slot's last word is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            for (int i = 0; i < NUM_SCANNERS; i++) begin
                if (capture[i]) begin
                    pending[i] <= 1'b1;
                end else if (last_accept && (out_source == SRC_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Sum simultaneous drops and saturate the counter at all-ones
    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_SCANNERS; i++) begin
            drop_num = drop_num + 5'(drop[i]);
        end
        drop_sum = SUM_W'(drop_count) + SUM_W'(drop_num);
        if (drop_sum > SUM_W'({DROP_CNT_W{1'b1}})) begin
            drop_next = '1;
        end else begin
            drop_next = drop_sum[DROP_CNT_W-1:0];
        end
    end

    // Drop counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_next;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next state: start on any pending slot, return to idle after the last word
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_valid) next_state = SEND;
            SEND:    if (last_accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Packet bookkeeping: latch the grant, step the word index, remember the last owner
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx   <= '0;
            out_source <= '0;
            last_grant <= SRC_W'(NUM_SCANNERS - 1);
        end else if (state == IDLE && grant_valid) begin
            out_source <= grant_idx;
            word_idx   <= '0;
        end else if (state == SEND && accept) begin
            if (word_idx == LAST_WORD) begin
                last_grant <= out_source;
                word_idx   <= '0;
            end else begin
                word_idx <= word_idx + 6'd1;
            end
        end
    end

    // FSM outputs and packet word mux from the granted slot
    always_comb begin
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_data  = '0;
        word_m1   = word_idx - 6'd1;
        lane_sel  = word_m1[5:1];
        if (state == SEND) begin
            out_valid = 1'b1;
            out_last  = (word_idx == LAST_WORD);
            if (word_idx == '0) begin
                out_data = nonce_reg[out_source];
            end else if (word_idx[0]) begin
                out_data = hash_reg[out_source][lane_sel][63:32];
            end else begin
                out_data = hash_reg[out_source][lane_sel][31:0];
            end
        end
    end

endmodule

// File: doc/sha3_result_dispatcher.md
# sha3_result_dispatcher

Collects scan results from `NUM_SCANNERS` SHA3 scanner cores and holds each in a one-deep capture slot per scanner. Picks pending slots round-robin and serializes each result as a 51-word, 32-bit valid/ready packet toward the host readout path. Sits between the scanner array's scan-result outputs and the host interface FIFO. Results arriving while the scanner's slot is still occupied are dropped and counted.

## Interface
- `NUM_SCANNERS`, 4: number of scanner inputs, 1..16.
- `DROP_CNT_W`, 16: width of the saturating drop counter.

- `clk`  in  1: single clock for the whole block.
- `rst_n`  in  1: reset, asynchronous assert, active-low. Deassertion is synchronized externally.
- `in_found`  in  NUM_SCANNERS: per-scanner result-valid qualifier, one cycle per result.
- `in_hash`  in  NUM_SCANNERS×25×64: per-scanner Keccak state, valid with `in_found`.
- `in_nonce`  in  NUM_SCANNERS×32: per-scanner nonce, valid with `in_found`.
- `out_valid`  out  1: packet word valid.
- `out_ready`  in  1: downstream accepts the word.
- `out_data`  out  32: packet word.
- `out_last`  out  1: high on word 50 of the packet.
- `out_source`  out  $clog2(NUM_SCANNERS) (min 1): index of the scanner owning the current packet; stable for the whole packet.
- `pending`  out  NUM_SCANNERS: slot-occupied flags.
- `drop_count`  out  DROP_CNT_W: saturating count of dropped results.

## Operation
- **Capture.** A result is captured when `in_found[i]=1` and slot i is free. Capture stores the hash and nonce and sets `pending[i]` on the next edge.
- **Drop.** If `in_found[i]=1` while `pending[i]=1`, the result is discarded and `drop_count` increments.
  - Drops on several scanners in the same cycle add the number of dropping scanners.
  - The counter saturates at all-ones.
- **Same-cycle free and refill.** If the last word of slot i is accepted in the same cycle that `in_found[i]=1`, the new result is captured, not dropped. `pending[i]` stays 1.
- **FSM states:** IDLE, SEND.
  - IDLE → SEND when `pending != 0`.
  - Grant goes to the first pending index strictly after `last_grant`, wrapping. `last_grant` resets to NUM_SCANNERS-1, so scanner 0 has first priority.
  - On the transition, latch the granted index into `out_source` and clear `word_idx` to 0.
  - SEND: `out_valid=1`. `word_idx` increments on each `out_valid & out_ready`.
  - SEND → IDLE when word 50 is accepted. At that point, clear `pending[source]` (unless refilled the same cycle) and set `last_grant=source`.
- **Packet format:**
  - Word 0 = nonce.
  - Word 2k+1 = hash[k][63:32] and word 2k+2 = hash[k][31:0], for k = 0..24.
  - `out_last` is high only at `word_idx=50`.
- **Slot stability.** `out_data` is muxed from the granted slot's registers. The granted slot is never overwritten while in SEND, because capture is blocked while it is pending.
- **Reset.** Asserting `rst_n` at any time, including mid-packet, immediately drives:
  - `out_valid=0`, `out_last=0`, `out_data=0`, `out_source=0`
  - `pending=0`, `drop_count=0`
  - state IDLE, `word_idx=0`

  The partial packet is abandoned.

## Timing
- Capture latency: `in_found` at cycle t gives `pending` high at t+1.
- First-word latency: `in_found` at t gives `out_valid` at t+2 (t+1 IDLE grant, t+2 SEND), provided the FSM was idle.
- Packet length: 51 accepted beats. With `out_ready` held high, a packet takes 51 cycles.
- Inter-packet gap: exactly one idle cycle (`out_valid=0`) between back-to-back packets.
- Valid/ready rules:
  - `out_data`, `out_last` and `out_source` hold stable while `out_valid & !out_ready`.
  - `out_valid` never drops mid-packet.
  - There is no combinational path from `out_ready` to `out_valid`.
- `drop_count` updates one cycle after the offending `in_found`.

## Structure
- Shared package `sha3_scan_pkg` holds the constants `HASH_LANES=25`, `HASH_WORDS32=50` and `RESULT_PKT_WORDS=51`, plus the `word_idx` typedef (6 bits).
- Sub-module `rr_arbiter` (parameter N): inputs `req[N]` and `last_grant`; outputs `grant_idx` and `grant_valid`. It is purely combinational.
- Capture slots, FSM, packet word mux and drop counter live in the top module.

## Test plan
- **Single result.** Scanner 2 pulses `in_found` with nonce 0xDEADBEEF and hash[k]={32'hA000_0000+k, 32'hB000_0000+k}, `out_ready=1`. Required:
  - `out_valid` at t+2, `out_source=2`.
  - Word 0 = 0xDEADBEEF, word 1 = 0xA0000000, word 2 = 0xB0000000, word 50 = 0xB0000018 with `out_last=1`.
  - `pending[2]` clears after word 50.
- **Round-robin.** Scanners 0, 1 and 3 fire in the same cycle. Required: packets emitted in source order 0, 1, 3, each 51 words, with one idle cycle between packets.
- **Drop.** Scanner 1 fires twice, 5 cycles apart, with `out_ready=0`. Required: `drop_count=1`, and the first result is the one emitted once `out_ready` rises.
- **Free and refill.** Scanner 0 fires in the same cycle its word 50 is accepted. Required: `drop_count` unchanged, and a second packet from scanner 0 follows after a 1-cycle gap.
- **Backpressure.** Toggle `out_ready` with a random 50% pattern. Required: `out_data`, `out_last` and `out_source` hold while stalled, and all 51 words arrive in order.
- **Reset mid-packet.** Drive `rst_n` low at word 20. Required: all outputs and `pending` are 0 immediately. After release, no residual packet is emitted until a new `in_found` arrives.
